// File: rtl/byte_receiver_if.sv
// Bus bundle between the I2C bus detectors, the byte receiver and the RX FIFO side.
interface byte_receiver_if #(
    parameter int LEN_W = 6
);
    logic             start_det;
    logic             stop_det;
    logic             sample_bit;
    logic             sda_in;
    logic [LEN_W-1:0] packet_length;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             ack_out;
    logic [LEN_W:0]   byte_count;
    logic             full;
    logic             overflow;

    modport master (
        output start_det, stop_det, sample_bit, sda_in, packet_length,
        input  rx_data, rx_valid, ack_out, byte_count, full, overflow
    );

    modport slave (
        input  start_det, stop_det, sample_bit, sda_in, packet_length,
        output rx_data, rx_valid, ack_out, byte_count, full, overflow
    );
endinterface

// File: rtl/byte_receiver.sv
// I2C slave receive path: deserialises SDA MSB first, counts bytes against a
// latched packet length and requests ACK/NACK for each received byte.
module byte_receiver #(
    parameter int LEN_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    byte_receiver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    // A programmed length of zero stands for the full 2**LEN_W bytes.
    function automatic logic [LEN_W:0] decode_len(input logic [LEN_W-1:0] pl);
        logic [LEN_W:0] r;
        r = '0;
        if (pl == '0) r[LEN_W] = 1'b1;
        else          r[LEN_W-1:0] = pl;
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [6:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [LEN_W:0] len_q, len_d;
    logic [LEN_W:0] byte_count_q, byte_count_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           ack_q, ack_d;
    logic           full_q, full_d;
    logic           overflow_q, overflow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            len_q        <= '0;
            byte_count_q <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            ack_q        <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            ack_q        <= ack_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        ack_d        = ack_q;
        full_d       = full_q;
        overflow_d   = overflow_q;

        if (bus.start_det) begin
            len_d        = decode_len(bus.packet_length);
            bit_cnt_d    = '0;
            byte_count_d = '0;
            full_d       = 1'b0;
            overflow_d   = 1'b0;
            ack_d        = 1'b0;
            state_d      = SHIFT;
        end else if (bus.stop_det) begin
            // Any strobe in the same cycle is dropped and a partial byte is lost.
            bit_cnt_d = '0;
            ack_d     = 1'b0;
            state_d   = IDLE;
        end else if (bus.sample_bit) begin
            unique case (state_q)
                SHIFT: begin
                    shift_d = {shift_q[5:0], bus.sda_in};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ACK;
                        if (!full_q) begin
                            rx_data_d    = {shift_q, bus.sda_in};
                            rx_valid_d   = 1'b1;
                            byte_count_d = byte_count_q + CNT_ONE;
                            ack_d        = 1'b1;
                            full_d       = ((byte_count_q + CNT_ONE) == len_q);
                        end else begin
                            overflow_d = 1'b1;
                            ack_d      = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ACK: begin
                    ack_d   = 1'b0;
                    state_d = SHIFT;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.ack_out    = ack_q;
    assign bus.byte_count = byte_count_q;
    assign bus.full       = full_q;
    assign bus.overflow   = overflow_q;
endmodule
